zbb_wb_buffer: RTL and testbench
================================

# zbb_wb_buffer

Writeback buffer directly downstream of the combinational Zbb execute unit. Captures each valid Zbb result (destination register plus 32-bit value) into a small in-order FIFO and drains it to the register-file write port under a valid/ready handshake. Optionally exposes a forwarding lookup so decode can bypass results still waiting in the buffer.

## Interface
Parameters:
- DEPTH, 2: number of FIFO entries; power of two, ≥2.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  execute stage presents an instruction result.
- in_ready  out  1  buffer accepts a transfer this cycle.
- in_isZbb  in  1  Zbb-unit "is Zbb instruction" flag for the presented instruction.
- in_rd  in  5  destination register index.
- in_data  in  32  Zbb-unit result.
- out_valid  out  1  head entry available for writeback.
- out_ready  in  1  register-file write port accepts the head.
- out_rd  out  5  head destination index; 0 when out_valid=0.
- out_data  out  32  head value; 0 when out_valid=0.
- count  out  $clog2(DEPTH)+1  current occupancy.
- byp_rs1, byp_rs2  in  5 each  source indices to search (present only with ZBB_BYPASS_EN).
- byp_hit1, byp_hit2  out  1 each  matching pending entry found.
- byp_data1, byp_data2  out  32 each  value of the youngest matching entry; 0 on miss.

## Operation
- Enqueue transfer: in_valid & in_ready at a rising edge.
- A transfer writes an entry only if in_isZbb=1 and in_rd≠0. Any other transfer is accepted and discarded, with no change to state.
- Dequeue: out_valid & out_ready at a rising edge. The head pointer advances and count decrements.
- in_ready = !rst & (count < DEPTH). It depends only on registered state, never on out_ready.
- out_valid = (count ≠ 0).
- Simultaneous enqueue and dequeue:
  - count unchanged.
  - Both pointers advance.
  - Legal at any occupancy with count<DEPTH.
- When full, enqueue is refused even if out_ready=1 in the same cycle.
- Ordering: strict FIFO. Pointers wrap modulo DEPTH.
- Storage: rd[4:0] and data[31:0] per entry. Entries beyond count are don't-care.
- Bypass lookup (combinational):
  - Scans only stored valid entries, youngest to oldest.
  - Returns the first entry whose rd equals the requested index.
  - Index 0 never hits.
  - The entry being dequeued in the current cycle still hits.
  - The input being enqueued does not hit.
- States: EMPTY (count=0), PARTIAL, FULL (count=DEPTH). Transitions are implied by the count arithmetic above; no separate FSM register.

## Timing
- Reset values: count=0, both pointers=0, out_valid=0, out_rd=0, out_data=0, in_ready=0 while rst=1. in_ready=1 in the first cycle after rst deasserts.
- Latency: an entry written at edge N appears on out_* in the cycle after N. There is no combinational path from in_* to out_*.
- out_rd/out_data stay stable while out_valid=1 and out_ready=0.
- Reset asserted mid-operation discards all entries at that edge, whatever the in/out handshakes are doing.
- Bypass outputs update combinationally from byp_rs* and the current registered state.

## Configuration
- ZBB_BYPASS_EN defined:
  - byp_* ports and the lookup logic are present.
- Undefined:
  - byp_* ports are absent.
  - No comparator logic.
  - All other behaviour is identical.

## Test plan
- Reset then idle: rst=1 for 2 cycles -> count=0, out_valid=0, out_data=0, in_ready=0 during reset and 1 after.
- Single pass: enqueue rd=5, data=0x0000_0020 (clz of 0) with out_ready=0 -> next cycle out_valid=1, out_rd=5, out_data=0x20. Then out_ready=1 -> count returns to 0.
- Filtering:
  - in_isZbb=0, rd=7, data=0xDEAD_BEEF -> count stays 0.
  - in_isZbb=1, rd=0 -> count stays 0.
- Full and simultaneous (DEPTH=2):
  - Fill with rd=1/0x11 and rd=2/0x22 -> in_ready=0.
  - Offer rd=3 with out_ready=1 -> rd=3 refused, rd=1 drained.
  - Next cycle enqueue rd=3 and dequeue rd=2 together -> count stays 1, output order is 1, 2, 3.
- Bypass (ZBB_BYPASS_EN):
  - Pending rd=4/0xAAAA_0000 (older) and rd=4/0x0000_5555 (younger), byp_rs1=4 -> byp_hit1=1, byp_data1=0x0000_5555.
  - byp_rs2=0 -> byp_hit2=0, byp_data2=0.
- Reset mid-operation: two entries pending, assert rst with out_ready=1 and in_valid=1 -> next cycle count=0, out_valid=0, no entry written.

Source files
------------

// File: rtl/zbb_wb_buffer_if.sv
// rtl/zbb_wb_buffer_if.sv - enqueue/drain handshake bundle for the Zbb writeback buffer
// Bypass lookup signals exist only when ZBB_BYPASS_EN is defined.
interface zbb_wb_buffer_if #(
   parameter int DEPTH = 2
);
   logic                     in_valid;
   logic                     in_ready;
   logic                     in_isZbb;
   logic [4:0]               in_rd;
   logic [31:0]              in_data;
   logic                     out_valid;
   logic                     out_ready;
   logic [4:0]               out_rd;
   logic [31:0]              out_data;
   logic [$clog2(DEPTH):0]   count;
`ifdef ZBB_BYPASS_EN
   logic [4:0]               byp_rs1;
   logic [4:0]               byp_rs2;
   logic                     byp_hit1;
   logic                     byp_hit2;
   logic [31:0]              byp_data1;
   logic [31:0]              byp_data2;

   modport slave (
      input  in_valid, in_isZbb, in_rd, in_data, out_ready, byp_rs1, byp_rs2,
      output in_ready, out_valid, out_rd, out_data, count,
             byp_hit1, byp_hit2, byp_data1, byp_data2
   );
   modport master (
      output in_valid, in_isZbb, in_rd, in_data, out_ready, byp_rs1, byp_rs2,
      input  in_ready, out_valid, out_rd, out_data, count,
             byp_hit1, byp_hit2, byp_data1, byp_data2
   );
`else
   modport slave (
      input  in_valid, in_isZbb, in_rd, in_data, out_ready,
      output in_ready, out_valid, out_rd, out_data, count
   );
   modport master (
      output in_valid, in_isZbb, in_rd, in_data, out_ready,
      input  in_ready, out_valid, out_rd, out_data, count
   );
`endif
endinterface

// File: rtl/zbb_wb_buffer.sv
// rtl/zbb_wb_buffer.sv - in-order FIFO between the Zbb execute unit and the register-file write port
// Optional forwarding lookup over pending entries is enabled by ZBB_BYPASS_EN.
module zbb_wb_buffer #(
   parameter int DEPTH = 2
) (
   input logic           clk,
   input logic           rst,
   zbb_wb_buffer_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [4:0]    rd_q   [DEPTH];
   logic [31:0]   data_q [DEPTH];
   logic [AW-1:0] wptr_q, rptr_q;
   logic [CW-1:0] count_q, count_d;
   logic          push, pop, in_ready;

   // in_ready looks only at registered occupancy, so a full buffer refuses even while draining
   assign in_ready = !rst && (count_q < FULL_CNT);
   assign push     = bus.in_valid && in_ready && bus.in_isZbb && (bus.in_rd != 5'd0);
   assign pop      = bus.out_ready && (count_q != '0);

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
         wptr_q  <= '0;
         rptr_q  <= '0;
      end else begin
         count_q <= count_d;
         if (push) begin
            rd_q[wptr_q]   <= bus.in_rd;
            data_q[wptr_q] <= bus.in_data;
            wptr_q         <= wptr_q + AW'(1);
         end
         if (pop) begin
            rptr_q <= rptr_q + AW'(1);
         end
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.count     = count_q;
   assign bus.out_valid = (count_q != '0);
   assign bus.out_rd    = (count_q != '0) ? rd_q[rptr_q]   : 5'd0;
   assign bus.out_data  = (count_q != '0) ? data_q[rptr_q] : 32'd0;

`ifdef ZBB_BYPASS_EN
   // Walk from the most recently written slot backwards; the first match is the youngest.
   function automatic logic [32:0] lookup(input logic [4:0] rs);
      logic [32:0]   res;
      logic [AW-1:0] idx;
      res = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = wptr_q - AW'(i + 1);
         if (!res[32] && (CW'(i) < count_q) && (rs != 5'd0) && (rd_q[idx] == rs)) begin
            res = {1'b1, data_q[idx]};
         end
      end
      return res;
   endfunction

   logic [32:0] hit1_res, hit2_res;

   always_comb begin
      hit1_res = lookup(bus.byp_rs1);
      hit2_res = lookup(bus.byp_rs2);
   end

   assign bus.byp_hit1  = hit1_res[32];
   assign bus.byp_data1 = hit1_res[31:0];
   assign bus.byp_hit2  = hit2_res[32];
   assign bus.byp_data2 = hit2_res[31:0];
`endif
endmodule

// File: tb/tb_zbb_wb_buffer.sv
// tb/tb_zbb_wb_buffer.sv - directed vector bench for zbb_wb_buffer (DEPTH=2)
module tb_zbb_wb_buffer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   zbb_wb_buffer_if #(.DEPTH(2)) bus ();

   zbb_wb_buffer #(.DEPTH(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   typedef struct {
      string       name;
      logic        in_valid;
      logic        is_zbb;
      logic [4:0]  rd;
      logic [31:0] data;
      logic        out_ready;
      logic [1:0]  e_count;
      logic        e_ovalid;
      logic [4:0]  e_ord;
      logic [31:0] e_odata;
      logic        e_iready;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic z, input logic [4:0] rd,
                        input logic [31:0] d, input logic ordy);
      bus.in_valid  = v;
      bus.in_isZbb  = z;
      bus.in_rd     = rd;
      bus.in_data   = d;
      bus.out_ready = ordy;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic add(input string n, input logic v, input logic z, input logic [4:0] rd,
                      input logic [31:0] d, input logic ordy, input logic [1:0] ec,
                      input logic eov, input logic [4:0] erd, input logic [31:0] ed, input logic eir);
      vec_t t;
      t.name = n; t.in_valid = v; t.is_zbb = z; t.rd = rd; t.data = d; t.out_ready = ordy;
      t.e_count = ec; t.e_ovalid = eov; t.e_ord = erd; t.e_odata = ed; t.e_iready = eir;
      vecs.push_back(t);
   endtask

   initial begin
      // name, in_valid, isZbb, rd, data, out_ready | count, out_valid, out_rd, out_data, in_ready after edge
      add("single_enq",   1, 1, 5'd5,  32'h0000_0020, 0, 2'd1, 1, 5'd5,  32'h0000_0020, 1);
      add("single_deq",   0, 0, 5'd0,  32'h0,         1, 2'd0, 0, 5'd0,  32'h0,         1);
      add("filt_nonzbb",  1, 0, 5'd7,  32'hDEAD_BEEF, 0, 2'd0, 0, 5'd0,  32'h0,         1);
      add("filt_rd0",     1, 1, 5'd0,  32'h0000_1234, 0, 2'd0, 0, 5'd0,  32'h0,         1);
      add("fill_1",       1, 1, 5'd1,  32'h0000_0011, 0, 2'd1, 1, 5'd1,  32'h0000_0011, 1);
      add("fill_2",       1, 1, 5'd2,  32'h0000_0022, 0, 2'd2, 1, 5'd1,  32'h0000_0011, 0);
      add("full_refuse",  1, 1, 5'd3,  32'h0000_0033, 1, 2'd1, 1, 5'd2,  32'h0000_0022, 1);
      add("simul_enqdeq", 1, 1, 5'd3,  32'h0000_0033, 1, 2'd1, 1, 5'd3,  32'h0000_0033, 1);
      add("drain_3",      0, 0, 5'd0,  32'h0,         1, 2'd0, 0, 5'd0,  32'h0,         1);
      add("hold_enq",     1, 1, 5'd9,  32'h0000_0099, 0, 2'd1, 1, 5'd9,  32'h0000_0099, 1);
      add("hold_stable",  0, 0, 5'd0,  32'h0,         0, 2'd1, 1, 5'd9,  32'h0000_0099, 1);
      add("wrap_enq",     1, 1, 5'd10, 32'h0000_00AA, 0, 2'd2, 1, 5'd9,  32'h0000_0099, 0);
      add("wrap_deq1",    0, 0, 5'd0,  32'h0,         1, 2'd1, 1, 5'd10, 32'h0000_00AA, 1);
      add("wrap_deq2",    0, 0, 5'd0,  32'h0,         1, 2'd0, 0, 5'd0,  32'h0,         1);

      drive(0, 0, 5'd0, 32'h0, 0);
`ifdef ZBB_BYPASS_EN
      bus.byp_rs1 = 5'd0;
      bus.byp_rs2 = 5'd0;
`endif
      rst = 1'b1;
      tick();
      chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
      chk("rst_count",    32'(bus.count),    32'd0);
      chk("rst_ovalid",   32'(bus.out_valid), 32'd0);
      chk("rst_odata",    bus.out_data,       32'd0);
      tick();
      rst = 1'b0;
      #1;
      chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

      // Presenting a valid result must not reach out_* before the edge.
      drive(1, 1, 5'd5, 32'h0000_0020, 0);
      #1;
      chk("no_comb_path_ovalid", 32'(bus.out_valid), 32'd0);

      foreach (vecs[i]) begin
         drive(vecs[i].in_valid, vecs[i].is_zbb, vecs[i].rd, vecs[i].data, vecs[i].out_ready);
         tick();
         chk({vecs[i].name, "_count"},  32'(bus.count),     32'(vecs[i].e_count));
         chk({vecs[i].name, "_ovalid"}, 32'(bus.out_valid), 32'(vecs[i].e_ovalid));
         chk({vecs[i].name, "_ord"},    32'(bus.out_rd),    32'(vecs[i].e_ord));
         chk({vecs[i].name, "_odata"},  bus.out_data,       vecs[i].e_odata);
         chk({vecs[i].name, "_iready"}, 32'(bus.in_ready),  32'(vecs[i].e_iready));
      end

`ifdef ZBB_BYPASS_EN
      drive(1, 1, 5'd4, 32'hAAAA_0000, 0);
      tick();
      drive(1, 1, 5'd4, 32'h0000_5555, 0);
      tick();
      drive(0, 0, 5'd0, 32'h0, 0);
      bus.byp_rs1 = 5'd4;
      bus.byp_rs2 = 5'd0;
      #1;
      chk("byp_hit1_young",  32'(bus.byp_hit1), 32'd1);
      chk("byp_data1_young", bus.byp_data1,     32'h0000_5555);
      chk("byp_hit2_rs0",    32'(bus.byp_hit2), 32'd0);
      chk("byp_data2_rs0",   bus.byp_data2,     32'd0);
      bus.byp_rs2 = 5'd7;
      #1;
      chk("byp_hit2_miss",   32'(bus.byp_hit2), 32'd0);
      drive(0, 0, 5'd0, 32'h0, 1);
      tick();
      chk("byp_after_deq_data1", bus.byp_data1, 32'h0000_5555);
      tick();
      chk("byp_empty_hit1", 32'(bus.byp_hit1), 32'd0);
      bus.byp_rs1 = 5'd0;
      bus.byp_rs2 = 5'd0;
      drive(0, 0, 5'd0, 32'h0, 0);
`endif

      // Mid-operation reset with both handshakes active.
      drive(1, 1, 5'd11, 32'h0000_0B0B, 0);
      tick();
      drive(1, 1, 5'd12, 32'h0000_0C0C, 0);
      tick();
      chk("pre_mrst_count", 32'(bus.count), 32'd2);
      drive(1, 1, 5'd13, 32'h0000_0D0D, 1);
      rst = 1'b1;
      tick();
      chk("mrst_count",  32'(bus.count),     32'd0);
      chk("mrst_ovalid", 32'(bus.out_valid), 32'd0);
      chk("mrst_ord",    32'(bus.out_rd),    32'd0);
      rst = 1'b0;
      drive(0, 0, 5'd0, 32'h0, 0);
      tick();
      chk("mrst_after_count",   32'(bus.count),    32'd0);
      chk("mrst_after_iready",  32'(bus.in_ready), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
